instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch port (PC, INSTRUCTION) and a slow block-wide instruction memory.
- Replaces the zero-wait-state combinational instruction array currently driven by the CPU testbench.
- Hits return the instruction combinationally in the same cycle.
- Misses stall the CPU via busywait while a full block is refilled from memory.

---
 rtl/instruction_cache.sv | 106 ++++++++++
 tb/tb_instruction_cache.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with same-cycle hits.
// A miss stalls the fetch port while a whole block is refilled from memory.
module instruction_cache #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = 10
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               read,
  input  logic [ADDR_W-1:0]                  address,
  output logic [31:0]                        instruction,
  output logic                               busywait,
  output logic                               mem_read,
  output logic [ADDR_W-OFFSET_W-3:0]         mem_address,
  input  logic [32*(2**OFFSET_W)-1:0]        mem_readdata,
  input  logic                               mem_busywait
);

  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINES   = 2**INDEX_W;
  localparam int BLK_W   = 32 * (2**OFFSET_W);
  localparam int BADDR_W = ADDR_W - OFFSET_W - 2;
  localparam int LSB_W   = OFFSET_W + 5;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tag_arr  [LINES];
  logic [BLK_W-1:0]     data_arr [LINES];
  logic [BADDR_W-1:0]   blk_addr;
  logic [BLK_W-1:0]     refill_blk;
  logic                 busy_r;

  logic [TAG_W-1:0]     tag;
  logic [INDEX_W-1:0]   index;
  logic [OFFSET_W-1:0]  offset;
  logic [TAG_W-1:0]     blk_tag;
  logic [INDEX_W-1:0]   blk_index;
  logic [BLK_W-1:0]     line_blk;
  logic [LSB_W-1:0]     word_lsb;
  logic                 hit;
  logic                 unused_addr_bits;

  assign tag              = address[ADDR_W-1 -: TAG_W];
  assign index            = address[OFFSET_W+2 +: INDEX_W];
  assign offset           = address[2 +: OFFSET_W];
  assign unused_addr_bits = ^address[1:0];
  assign blk_tag          = blk_addr[BADDR_W-1 -: TAG_W];
  assign blk_index        = blk_addr[INDEX_W-1:0];

  assign line_blk    = data_arr[index];
  assign word_lsb    = {offset, 5'b0};
  assign hit         = read & valid[index] & (tag_arr[index] == tag);
  assign instruction = hit ? line_blk[word_lsb +: 32] : 32'h0;

  // In IDLE the stall follows the lookup directly; RESET gates it so the CPU is released at once.
  assign busywait    = (state == IDLE) ? (read & ~hit & ~RESET) : busy_r;
  assign mem_address = blk_addr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      valid    <= '0;
      blk_addr <= '0;
      mem_read <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !hit) begin
            blk_addr <= {tag, index};
            mem_read <= 1'b1;
            busy_r   <= 1'b1;
            state    <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            mem_read <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid[blk_index] <= 1'b1;
          busy_r           <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: no reset; an aborted refill never reaches UPDATE, so its block is never written.
  always_ff @(posedge CLK) begin
    if (state == MEM_READ && !mem_busywait) begin
      refill_blk <= mem_readdata;
    end
    if (state == UPDATE) begin
      data_arr[blk_index] <= refill_blk;
      tag_arr[blk_index]  <= blk_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: reset, cold/conflict misses, hits,
// address change during refill and reset in the middle of a refill.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         read = 1'b0;
  logic [9:0]   address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] BLK0 = {32'h00070109, 32'h00060101, 32'h00050001, 32'h0704000A};
  localparam logic [127:0] BLK1 = {32'h11110013, 32'h11110012, 32'h11110011, 32'h11110010};
  localparam logic [127:0] BLK8 = {32'h88880003, 32'h88880002, 32'h88880001, 32'h88880000};
  localparam logic [127:0] BLK2 = {32'h22220003, 32'h22220002, 32'h22220001, 32'h22220000};
  localparam logic [127:0] BLK3 = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
  localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called one step after an edge in the IDLE cycle that detected the miss.
  task automatic refill(input string tag, input logic [5:0] exp_baddr,
                        input logic [127:0] blk, input int busy_cycles);
    mem_busywait = 1'b1;
    mem_readdata = JUNK;
    @(posedge CLK); #1;
    for (int i = 0; i < busy_cycles; i++) begin
      chk({tag, "_mem_read"}, 32'(mem_read), 32'd1);
      chk({tag, "_mem_addr"}, 32'(mem_address), 32'(exp_baddr));
      chk({tag, "_busy_mr"}, 32'(busywait), 32'd1);
      @(posedge CLK); #1;
    end
    mem_busywait = 1'b0;
    mem_readdata = blk;
    chk({tag, "_mem_read_last"}, 32'(mem_read), 32'd1);
    @(posedge CLK); #1;
    mem_busywait = 1'b1;
    mem_readdata = JUNK;
    chk({tag, "_upd_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_upd_busy"}, 32'(busywait), 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    read = 1'b1;
    address = 10'h000;
    #1 RESET = 1'b1;
    #2;
    chk("rst_busy", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_mem_addr", 32'(mem_address), 32'h0);
    #3 RESET = 1'b0;
    #1;
    chk("cold_busy", 32'(busywait), 32'd1);
    chk("cold_instr", instruction, 32'h0);
    chk("cold_mem_read_idle", 32'(mem_read), 32'd0);

    refill("cold", 6'h00, BLK0, 5);
    chk("cold_hit_instr", instruction, 32'h0704000A);
    chk("cold_hit_busy", 32'(busywait), 32'd0);

    address = 10'h004; @(posedge CLK); #1;
    chk("seq4_instr", instruction, 32'h00050001);
    chk("seq4_busy", 32'(busywait), 32'd0);
    chk("seq4_mem_read", 32'(mem_read), 32'd0);
    address = 10'h008; @(posedge CLK); #1;
    chk("seq8_instr", instruction, 32'h00060101);
    chk("seq8_busy", 32'(busywait), 32'd0);
    chk("seq8_mem_read", 32'(mem_read), 32'd0);
    address = 10'h00C; @(posedge CLK); #1;
    chk("seqC_instr", instruction, 32'h00070109);
    chk("seqC_busy", 32'(busywait), 32'd0);
    chk("seqC_mem_read", 32'(mem_read), 32'd0);

    read = 1'b0; address = 10'h3F0; #1;
    chk("noread_busy", 32'(busywait), 32'd0);
    chk("noread_instr", instruction, 32'h0);
    @(posedge CLK); #1;
    chk("noread_mem_read", 32'(mem_read), 32'd0);
    read = 1'b1;

    address = 10'h010; #1;
    chk("l1_busy", 32'(busywait), 32'd1);
    refill("l1", 6'h01, BLK1, 2);
    chk("l1_instr", instruction, 32'h11110010);
    address = 10'h01C; #1;
    chk("l1_w3_instr", instruction, 32'h11110013);

    address = 10'h080; #1;
    chk("conf_busy", 32'(busywait), 32'd1);
    refill("conf", 6'h08, BLK8, 1);
    chk("conf_instr", instruction, 32'h88880000);
    address = 10'h088; #1;
    chk("conf_w2_instr", instruction, 32'h88880002);
    address = 10'h000; #1;
    chk("evict_busy", 32'(busywait), 32'd1);
    chk("evict_instr", instruction, 32'h0);
    refill("evict", 6'h00, BLK0, 0);
    chk("evict_refill_instr", instruction, 32'h0704000A);

    address = 10'h020; #1;
    chk("chg_busy", 32'(busywait), 32'd1);
    mem_busywait = 1'b1;
    @(posedge CLK); #1;
    address = 10'h040; #1;
    chk("chg_mem_addr0", 32'(mem_address), 32'h02);
    chk("chg_mem_read0", 32'(mem_read), 32'd1);
    @(posedge CLK); #1;
    chk("chg_mem_addr1", 32'(mem_address), 32'h02);
    mem_busywait = 1'b0;
    mem_readdata = BLK2;
    @(posedge CLK); #1;
    mem_busywait = 1'b1;
    mem_readdata = JUNK;
    chk("chg_upd_busy", 32'(busywait), 32'd1);
    chk("chg_upd_mem_read", 32'(mem_read), 32'd0);
    @(posedge CLK); #1;
    chk("chg_new_miss_busy", 32'(busywait), 32'd1);
    chk("chg_new_miss_instr", instruction, 32'h0);
    address = 10'h020; #1;
    chk("chg_l2_instr", instruction, 32'h22220000);
    chk("chg_l2_busy", 32'(busywait), 32'd0);
    address = 10'h024; #1;
    chk("chg_l2_w1_instr", instruction, 32'h22220001);

    address = 10'h030; #1;
    chk("abort_busy", 32'(busywait), 32'd1);
    mem_busywait = 1'b1;
    @(posedge CLK); #1;
    chk("abort_mem_read_pre", 32'(mem_read), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_busy_rst", 32'(busywait), 32'd0);
    #1 RESET = 1'b0;
    #1;
    chk("abort_remiss_busy", 32'(busywait), 32'd1);
    chk("abort_remiss_instr", instruction, 32'h0);
    refill("abort_refill", 6'h03, BLK3, 3);
    chk("abort_l3_instr", instruction, 32'h33330000);
    address = 10'h03C; #1;
    chk("abort_l3_w3_instr", instruction, 32'h33330003);
    address = 10'h000; #1;
    chk("post_rst_l0_miss", 32'(busywait), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
